mc14500b_loader: RTL and testbench

Program-load master for the MC14500B core. It takes a byte stream in over a valid/ready handshake, frames the stream into 12-bit program commands, and drives the core's program_write/program_cmd load port. It also sequences the core reset around the load: reset before load to clear the program pointer, reset after load to start execution. It sits between a host byte source (UART/debug bridge) and the MC14500B core.

---
 rtl/mc14500b_loader.sv | 206 ++++++++++++++++++++
 tb/tb_mc14500b_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc14500b_loader.sv
// Program-load master for the MC14500B core: frames a byte stream into 12-bit
// program commands and sequences core reset before and after the load.
module mc14500b_loader #(
  parameter int WR_PULSE   = 1,
  parameter int GAP_CYCLES = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic        program_write,
  output logic [11:0] program_cmd,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PRE_RST  = 4'd1,
    S_BYTE_HI  = 4'd2,
    S_BYTE_LO  = 4'd3,
    S_WRITE    = 4'd4,
    S_GAP      = 4'd5,
    S_POST_RST = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] WR_LAST  = 16'(WR_PULSE - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic        HAS_GAP  = (GAP_CYCLES != 0);

  state_t      state_r, state_next_s;
  logic [15:0] cnt_r, cnt_next_s;
  logic [8:0]  rem_r, rem_next_s;
  logic [11:0] cmd_r, cmd_next_s;
  logic        ready_r, pw_r, core_rst_r, busy_r, done_r, error_r;
  logic        ready_next_s, pw_next_s, core_rst_next_s, busy_next_s, done_next_s, error_next_s;
  logic        xfer_s;

  assign xfer_s = in_valid & ready_r;

  // Next-state, counter and command-latch logic; abort overrides everything.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    rem_next_s   = rem_r;
    cmd_next_s   = cmd_r;
    if (abort) begin
      state_next_s = S_IDLE;
      cnt_next_s   = 16'd0;
      rem_next_s   = 9'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (xfer_s) begin
            rem_next_s   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            cnt_next_s   = 16'd0;
            state_next_s = S_PRE_RST;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_PRE_RST: begin
          if (cnt_r == RST_LAST) begin
            cnt_next_s   = 16'd0;
            state_next_s = S_BYTE_HI;
          end else begin
            cnt_next_s = cnt_r + 16'd1;
          end
        end
        S_BYTE_HI: begin
          if (xfer_s) begin
            if (in_data[7:4] != 4'h0) begin
              state_next_s = S_ERR;
            end else begin
              cmd_next_s[11:8] = in_data[3:0];
              state_next_s     = S_BYTE_LO;
            end
          end else begin
            state_next_s = S_BYTE_HI;
          end
        end
        S_BYTE_LO: begin
          if (xfer_s) begin
            cmd_next_s[7:0] = in_data;
            cnt_next_s      = 16'd0;
            state_next_s    = S_WRITE;
          end else begin
            state_next_s = S_BYTE_LO;
          end
        end
        S_WRITE: begin
          if (cnt_r == WR_LAST) begin
            cnt_next_s = 16'd0;
            rem_next_s = rem_r - 9'd1;
            // remaining is decremented this cycle, so 1 here means the last command
            if (HAS_GAP) begin
              state_next_s = S_GAP;
            end else if (rem_r == 9'd1) begin
              state_next_s = S_POST_RST;
            end else begin
              state_next_s = S_BYTE_HI;
            end
          end else begin
            cnt_next_s = cnt_r + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_next_s   = 16'd0;
            state_next_s = (rem_r == 9'd0) ? S_POST_RST : S_BYTE_HI;
          end else begin
            cnt_next_s = cnt_r + 16'd1;
          end
        end
        S_POST_RST: begin
          if (cnt_r == RST_LAST) begin
            cnt_next_s   = 16'd0;
            state_next_s = S_DONE;
          end else begin
            cnt_next_s = cnt_r + 16'd1;
          end
        end
        S_DONE: begin
          state_next_s = S_IDLE;
        end
        S_ERR: begin
          state_next_s = S_ERR;
        end
        default: begin
          state_next_s = S_IDLE;
          cnt_next_s   = 16'd0;
          rem_next_s   = 9'd0;
        end
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    ready_next_s    = 1'b0;
    pw_next_s       = 1'b0;
    core_rst_next_s = 1'b0;
    busy_next_s     = 1'b1;
    done_next_s     = 1'b0;
    error_next_s    = 1'b0;
    case (state_next_s)
      S_IDLE: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b0;
      end
      S_BYTE_HI, S_BYTE_LO: ready_next_s = 1'b1;
      S_WRITE:              pw_next_s = 1'b1;
      S_PRE_RST, S_POST_RST: core_rst_next_s = 1'b1;
      S_DONE:               done_next_s = 1'b1;
      S_ERR: begin
        core_rst_next_s = 1'b1;
        error_next_s    = 1'b1;
      end
      default: busy_next_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= 16'd0;
      rem_r      <= 9'd0;
      cmd_r      <= 12'h000;
      ready_r    <= 1'b0;
      pw_r       <= 1'b0;
      core_rst_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      rem_r      <= rem_next_s;
      cmd_r      <= cmd_next_s;
      ready_r    <= ready_next_s;
      pw_r       <= pw_next_s;
      core_rst_r <= core_rst_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      error_r    <= error_next_s;
    end
  end

  assign in_ready      = ready_r;
  assign program_write = pw_r;
  assign program_cmd   = cmd_r;
  assign core_rst      = core_rst_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_mc14500b_loader.sv
// Self-checking bench for mc14500b_loader: scoreboard of expected program
// commands, popped on every program_write rising edge.
module tb_mc14500b_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        use2 = 1'b0;

  logic        rdy1, pw1, cr1, busy1, done1, err1;
  logic        rdy2, pw2, cr2, busy2, done2, err2;
  logic [11:0] cmd1, cmd2;
  logic        in_ready_s, pw_s, core_rst_s, busy_s, done_s, error_s;
  logic [11:0] cmd_s;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  pair_hi[256];
  logic [7:0]  pair_lo[256];
  int wr_count = 0;
  int done_count = 0;
  logic [11:0] last_cmd = 12'h000;

  always #5 clk = ~clk;

  mc14500b_loader dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid & ~use2),
    .in_ready(rdy1), .abort(abort), .program_write(pw1), .program_cmd(cmd1),
    .core_rst(cr1), .busy(busy1), .done(done1), .error(err1));

  mc14500b_loader #(.WR_PULSE(3), .GAP_CYCLES(0), .RST_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid & use2),
    .in_ready(rdy2), .abort(abort), .program_write(pw2), .program_cmd(cmd2),
    .core_rst(cr2), .busy(busy2), .done(done2), .error(err2));

  assign in_ready_s = use2 ? rdy2  : rdy1;
  assign pw_s       = use2 ? pw2   : pw1;
  assign cmd_s      = use2 ? cmd2  : cmd1;
  assign core_rst_s = use2 ? cr2   : cr1;
  assign busy_s     = use2 ? busy2 : busy1;
  assign done_s     = use2 ? done2 : done1;
  assign error_s    = use2 ? err2  : err1;

  // Scoreboard consumer and protocol monitor on the active DUT.
  logic        pw_prev = 1'b0;
  logic        err_prev = 1'b0;
  logic [11:0] cur_exp = 12'h000;
  int          hi_len = 0;
  int          rst_len = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready_s && (pw_s || core_rst_s)) begin
        failures++;
        $display("FAIL ready_excl in_ready=%0b program_write=%0b core_rst=%0b want in_ready=0", in_ready_s, pw_s, core_rst_s);
      end
      if (pw_s) begin
        if (!pw_prev) begin
          wr_count++;
          hi_len = 1;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty got cmd=%03h want no write", cmd_s);
            cur_exp = cmd_s;
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end else begin
          hi_len++;
        end
        checks++;
        if (cmd_s !== cur_exp) begin
          failures++;
          $display("FAIL cmd got %03h want %03h", cmd_s, cur_exp);
        end
        last_cmd = cmd_s;
      end else if (pw_prev) begin
        checks++;
        if (hi_len != (use2 ? 3 : 1)) begin
          failures++;
          $display("FAIL pulse_len got %0d want %0d", hi_len, use2 ? 3 : 1);
        end
      end
      if (core_rst_s) begin
        rst_len++;
      end else begin
        if (rst_len != 0 && !err_prev) begin
          checks++;
          if (rst_len != 2) begin
            failures++;
            $display("FAIL rst_len got %0d want 2", rst_len);
          end
        end
        rst_len = 0;
      end
      if (done_s) done_count++;
    end else begin
      rst_len = 0;
    end
    pw_prev  = pw_s;
    err_prev = error_s;
  end

  task automatic send(input logic [7:0] b, input int stall);
    int t;
    if (stall > 0) begin
      in_valid = 1'b0;
      repeat (stall) @(negedge clk);
    end
    in_data = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready_s && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready_s) begin
      failures++;
      $display("FAIL send_timeout byte=%02h in_ready=%0b want 1", b, in_ready_s);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic fill_table10();
    logic [15:0] tbl[10];
    tbl = '{16'h06FF, 16'h0AFF, 16'h0BFF, 16'h0800, 16'h0700,
            16'h02FF, 16'h0800, 16'h0801, 16'h0802, 16'h0C05};
    for (int i = 0; i < 10; i++) begin
      pair_hi[i] = tbl[i][15:8];
      pair_lo[i] = tbl[i][7:0];
    end
  endtask

  task automatic do_load(input logic [7:0] hdr, input int np, input bit stall);
    int t;
    wr_count = 0;
    done_count = 0;
    send(hdr, stall ? 2 : 0);
    checks++;
    if (core_rst_s !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst got core_rst=%0b want 1", core_rst_s);
    end
    for (int i = 0; i < np; i++) begin
      exp_q.push_back({pair_hi[i][3:0], pair_lo[i]});
      send(pair_hi[i], stall ? ((i % 2 == 1) ? 3 : 1) : 0);
      send(pair_lo[i], stall ? 1 : 0);
    end
    t = 0;
    while (done_s !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_s !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout got done=%0b want 1", done_s);
    end
    @(negedge clk);
    checks++;
    if ({busy_s, done_s, in_ready_s, core_rst_s} !== 4'b0010) begin
      failures++;
      $display("FAIL post_done got busy/done/ready/rst=%04b want 0010", {busy_s, done_s, in_ready_s, core_rst_s});
    end
    checks++;
    if (wr_count != np) begin
      failures++;
      $display("FAIL wr_count got %0d want %0d", wr_count, np);
    end
    checks++;
    if (done_count != 1) begin
      failures++;
      $display("FAIL done_count got %0d want 1", done_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_left got %0d entries want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready_s, pw_s, cmd_s, core_rst_s, busy_s, done_s, error_s} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outputs got %05h want 00000", {in_ready_s, pw_s, cmd_s, core_rst_s, busy_s, done_s, error_s});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_s !== 1'b1 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready got in_ready=%0b busy=%0b want 1 0", in_ready_s, busy_s);
    end
  endtask

  task automatic test_back_to_back();
    fill_table10();
    do_load(8'd10, 10, 1'b0);
  endtask

  task automatic test_stall();
    fill_table10();
    do_load(8'd10, 10, 1'b1);
  endtask

  task automatic test_error();
    wr_count = 0;
    send(8'h01, 0);
    send(8'h35, 0);
    repeat (4) @(negedge clk);
    checks++;
    if ({error_s, core_rst_s, in_ready_s, pw_s, busy_s} !== 5'b11001) begin
      failures++;
      $display("FAIL err_state got err/rst/ready/pw/busy=%05b want 11001", {error_s, core_rst_s, in_ready_s, pw_s, busy_s});
    end
    checks++;
    if (wr_count != 0) begin
      failures++;
      $display("FAIL err_writes got %0d want 0", wr_count);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({error_s, core_rst_s, in_ready_s, busy_s} !== 4'b0010) begin
      failures++;
      $display("FAIL abort got err/rst/ready/busy=%04b want 0010", {error_s, core_rst_s, in_ready_s, busy_s});
    end
  endtask

  task automatic test_256();
    for (int i = 0; i < 256; i++) begin
      pair_hi[i] = 8'(i % 16);
      pair_lo[i] = 8'(i);
    end
    do_load(8'd0, 256, 1'b0);
    checks++;
    if (last_cmd !== 12'hFFF) begin
      failures++;
      $display("FAIL last_cmd got %03h want fff", last_cmd);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    fill_table10();
    send(8'd10, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({pair_hi[i][3:0], pair_lo[i]});
      send(pair_hi[i], 0);
      send(pair_lo[i], 0);
    end
    t = 0;
    while (pw_s !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_s, pw_s, cmd_s, core_rst_s, busy_s, done_s, error_s} !== 18'h0) begin
      failures++;
      $display("FAIL mid_reset got %05h want 00000", {in_ready_s, pw_s, cmd_s, core_rst_s, busy_s, done_s, error_s});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pair_hi[0] = 8'h03; pair_lo[0] = 8'h12;
    pair_hi[1] = 8'h0E; pair_lo[1] = 8'h34;
    do_load(8'd2, 2, 1'b0);
  endtask

  task automatic test_wr3();
    int t;
    use2 = 1'b1;
    @(negedge clk);
    pair_hi[0] = 8'h01; pair_lo[0] = 8'h23;
    pair_hi[1] = 8'h0F; pair_lo[1] = 8'h45;
    pair_hi[2] = 8'h09; pair_lo[2] = 8'h67;
    wr_count = 0;
    done_count = 0;
    send(8'd3, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({pair_hi[i][3:0], pair_lo[i]});
      send(pair_hi[i], 0);
      send(pair_lo[i], 0);
      if (i < 2) begin
        t = 0;
        while (pw_s && t < 20) begin
          @(negedge clk);
          t++;
        end
        checks++;
        if (t != 3 || in_ready_s !== 1'b1) begin
          failures++;
          $display("FAIL wr3_gap0 got high=%0d ready=%0b want 3 1", t, in_ready_s);
        end
      end
    end
    t = 0;
    while (done_s !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    checks++;
    if (wr_count != 3 || done_count != 1 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL wr3_end got writes=%0d dones=%0d busy=%0b want 3 1 0", wr_count, done_count, busy_s);
    end
    use2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_error();
    test_256();
    test_reset_mid();
    test_wr3();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
